// File: rtl/link_peer_if.sv
// Link-cable pin and host-side handshake bundle for the link_peer far-end model.
// The slave modport is the peer's view; the master modport is the environment driving it.
interface link_peer_if;
    logic       sck_in;
    logic       sout;
    logic       sin;
    logic       sck_out;
    logic       sck_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       start;
    logic       timeout_err;

    modport slave (
        input  sck_in, sout, tx_data, tx_valid, start,
        output sin, sck_out, sck_oe, tx_ready, rx_data, rx_valid, busy, timeout_err
    );

    modport master (
        output sck_in, sout, tx_data, tx_valid, start,
        input  sin, sck_out, sck_oe, tx_ready, rx_data, rx_valid, busy, timeout_err
    );
endinterface

// File: rtl/link_peer.sv
// Far end of the DMG link-cable serial port: shifts bytes MSB first against SCK.
// Define LINK_PEER_MASTER_EN to build the optional clock-master (sck_out) generator.
module link_peer #(
    parameter int HALF_PERIOD = 256,
    parameter int TIMEOUT     = 4096
) (
    input  logic         clk,
    input  logic         nreset,
    link_peer_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t        state_q;
    logic          sck_s1_q, sck_s2_q, sck_prev_q;
    logic          edge_fall, edge_rise;
    logic          tx_full_q, tx_full_d;
    logic [7:0]    tx_buf_q;
    logic [7:0]    tx_sr_q;
    logic [7:0]    rx_sr_q;
    logic [7:0]    rx_data_q;
    logic [7:0]    load_byte;
    logic [2:0]    bit_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          sin_q, busy_q, rx_valid_q, timeout_err_q;
    logic          accept, byte_start, consume, shift_tx, shift_rx;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sck_s1_q   <= 1'b1;
            sck_s2_q   <= 1'b1;
            sck_prev_q <= 1'b1;
        end else begin
            sck_s1_q   <= bus.sck_in;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
        end
    end

`ifdef LINK_PEER_MASTER_EN
    localparam int HW = $clog2(HALF_PERIOD + 1);

    typedef enum logic [1:0] {M_IDLE, M_LOW, M_HIGH} mstate_t;

    mstate_t       mstate_q;
    logic [HW-1:0] hcnt_q;
    logic [2:0]    pcnt_q;
    logic          sck_out_q, sck_oe_q, msck_prev_q;
    logic          start_ok;

    assign start_ok = bus.start && (state_q == S_IDLE) && (mstate_q == M_IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mstate_q    <= M_IDLE;
            hcnt_q      <= '0;
            pcnt_q      <= '0;
            sck_out_q   <= 1'b1;
            sck_oe_q    <= 1'b0;
            msck_prev_q <= 1'b1;
        end else begin
            msck_prev_q <= sck_out_q;
            case (mstate_q)
                M_IDLE: begin
                    if (start_ok) begin
                        sck_oe_q  <= 1'b1;
                        sck_out_q <= 1'b0;
                        hcnt_q    <= '0;
                        pcnt_q    <= '0;
                        mstate_q  <= M_LOW;
                    end
                end
                M_LOW: begin
                    if (hcnt_q == HW'(HALF_PERIOD - 1)) begin
                        sck_out_q <= 1'b1;
                        hcnt_q    <= '0;
                        mstate_q  <= M_HIGH;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                M_HIGH: begin
                    // The eighth rising edge ends the byte; release the net on the next clk.
                    if (pcnt_q == 3'd7) begin
                        sck_oe_q <= 1'b0;
                        mstate_q <= M_IDLE;
                    end else if (hcnt_q == HW'(HALF_PERIOD - 1)) begin
                        sck_out_q <= 1'b0;
                        hcnt_q    <= '0;
                        pcnt_q    <= pcnt_q + 3'd1;
                        mstate_q  <= M_LOW;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                default: mstate_q <= M_IDLE;
            endcase
        end
    end

    assign edge_fall   = sck_oe_q ? (msck_prev_q & ~sck_out_q) : (sck_prev_q & ~sck_s2_q);
    assign edge_rise   = sck_oe_q ? (~msck_prev_q & sck_out_q) : (~sck_prev_q & sck_s2_q);
    assign bus.sck_out = sck_out_q;
    assign bus.sck_oe  = sck_oe_q;
`else
    logic unused_cfg;

    assign unused_cfg  = bus.start | (HALF_PERIOD == 0);
    assign edge_fall   = sck_prev_q & ~sck_s2_q;
    assign edge_rise   = ~sck_prev_q & sck_s2_q;
    assign bus.sck_out = 1'b1;
    assign bus.sck_oe  = 1'b0;
`endif

    // A start in the same cycle as an accept still sees the old buffer state.
    assign accept     = bus.tx_valid && !tx_full_q;
    assign byte_start = (state_q == S_IDLE) && edge_fall;
    assign consume    = byte_start && tx_full_q;
    assign load_byte  = tx_full_q ? tx_buf_q : 8'hFF;
    assign shift_rx   = (state_q == S_SHIFT) && edge_rise;
    assign shift_tx   = (state_q == S_SHIFT) && edge_fall && !edge_rise;

    always_comb begin
        tx_full_d = tx_full_q;
        if (accept) begin
            tx_full_d = 1'b1;
        end else if (consume) begin
            tx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_buf_q <= bus.tx_data;
        end
        if (byte_start) begin
            tx_sr_q <= {load_byte[6:0], 1'b0};
        end else if (shift_tx) begin
            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
        end
        if (shift_rx) begin
            rx_sr_q <= {rx_sr_q[6:0], bus.sout};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= S_IDLE;
            tx_full_q     <= 1'b0;
            bit_cnt_q     <= '0;
            to_cnt_q      <= '0;
            sin_q         <= 1'b1;
            busy_q        <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_full_q     <= tx_full_d;
            rx_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (edge_fall) begin
                        sin_q     <= load_byte[7];
                        bit_cnt_q <= '0;
                        to_cnt_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (edge_rise) begin
                        to_cnt_q  <= '0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {rx_sr_q[6:0], bus.sout};
                            rx_valid_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (edge_fall) begin
                        to_cnt_q <= '0;
                        sin_q    <= tx_sr_q[7];
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        // Stalled mid-byte: drop the partial byte, keep the last good rx_data.
                        to_cnt_q      <= '0;
                        bit_cnt_q     <= '0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.sin         = sin_q;
    assign bus.tx_ready    = ~tx_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_link_peer.sv
// Randomized scoreboard bench for link_peer acting as the DMG link partner.
module tb_link_peer;
    localparam int HP = 256;
    localparam int TO = 4096;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    logic sck_drv = 1'b1;

    always #5 clk = ~clk;

    link_peer_if bus ();
    assign bus.sck_in = bus.sck_oe ? bus.sck_out : sck_drv;

    link_peer #(.HALF_PERIOD(HP), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    typedef struct {
        bit         is_to;
        logic [7:0] data;
    } ev_t;

    ev_t        expq[$];
    ev_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    longint     to_cyc = 0;
    longint     last_rise_cyc = 0;
    bit         m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    logic [7:0] m_last = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every rx_valid or timeout_err pulse is matched against the expectation queue.
    always @(negedge clk) begin
        if (nreset && (bus.rx_valid || bus.timeout_err)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event rx_valid=%0b timeout_err=%0b required=none",
                         bus.rx_valid, bus.timeout_err);
            end else begin
                mon_e = expq.pop_front();
                chk("event_kind_timeout", {31'd0, bus.timeout_err}, {31'd0, mon_e.is_to});
                chk(mon_e.is_to ? "rx_data_kept" : "rx_data", {24'd0, bus.rx_data}, {24'd0, mon_e.data});
                if (bus.timeout_err) to_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        int k = 0;
        while (!bus.tx_ready && k < 100) begin
            tick(1);
            k++;
        end
        chk("tx_ready_before_load", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        m_full = 1'b1;
        m_buf  = b;
    endtask

    // DMG side: drive sout on the falling edge, sample sin just before the rising edge.
    task automatic dmg_byte(input logic [7:0] d, input int hp, input int nbits,
                            input bit simul, input logic [7:0] sdata, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck_drv  = 1'b0;
            bus.sout = d[7-i];
            if (i == 0 && simul) begin
                tick(2);
                bus.tx_data  = sdata;
                bus.tx_valid = 1'b1;
                tick(1);
                bus.tx_valid = 1'b0;
                tick(hp - 3);
            end else begin
                tick(hp);
            end
            got     = {got[6:0], bus.sin};
            sck_drv = 1'b1;
            last_rise_cyc = cyc;
            tick(hp);
        end
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (expq.size() != 0 && k < limit) begin
            tick(1);
            k++;
        end
        chk("events_drained", expq.size(), 32'd0);
    endtask

    task automatic xfer(input logic [7:0] d, input int hp);
        logic [7:0] send;
        logic [7:0] got;
        send   = m_full ? m_buf : 8'hFF;
        m_full = 1'b0;
        expq.push_back('{is_to: 1'b0, data: d});
        dmg_byte(d, hp, 8, 1'b0, 8'h00, got);
        chk("sin_byte", {24'd0, got}, {24'd0, send});
        m_last = d;
        wait_drain(50);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sin"},         {31'd0, bus.sin},         32'd1);
        chk({tag, "_sck_out"},     {31'd0, bus.sck_out},     32'd1);
        chk({tag, "_sck_oe"},      {31'd0, bus.sck_oe},      32'd0);
        chk({tag, "_tx_ready"},    {31'd0, bus.tx_ready},    32'd1);
        chk({tag, "_rx_data"},     {24'd0, bus.rx_data},     32'd0);
        chk({tag, "_rx_valid"},    {31'd0, bus.rx_valid},    32'd0);
        chk({tag, "_busy"},        {31'd0, bus.busy},        32'd0);
        chk({tag, "_timeout_err"}, {31'd0, bus.timeout_err}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] d;
        longint     delta;
        int         n;

        bus.sout     = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.start    = 1'b0;
        tick(3);
        chk_reset_outputs("por");
        nreset = 1'b1;
        tick(3);

        // Slave exchange at 8192 Hz
        load_tx(8'hA5);
        chk("tx_ready_after_load", {31'd0, bus.tx_ready}, 32'd0);
        xfer(8'h3C, HP);
        chk("tx_ready_after_byte", {31'd0, bus.tx_ready}, 32'd1);

        // Empty buffer sends the disconnected-cable value
        xfer(8'h00, HP);

        // tx_valid in the same cycle as the first detected falling edge
        expq.push_back('{is_to: 1'b0, data: 8'h6B});
        dmg_byte(8'h6B, 8, 8, 1'b1, 8'h11, got);
        chk("simul_sin_byte", {24'd0, got}, 32'hFF);
        m_full = 1'b1;
        m_buf  = 8'h11;
        m_last = 8'h6B;
        wait_drain(50);
        chk("simul_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        xfer(8'hE2, 8);

        // Randomized traffic
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
            d = 8'($urandom);
            xfer(d, $urandom_range(4, 16));
            chk("busy_after_byte", {31'd0, bus.busy}, 32'd0);
        end

        // Timeout after 5 rising edges; the consumed tx byte is lost
        load_tx(8'h5E);
        m_full = 1'b0;
        expq.push_back('{is_to: 1'b1, data: m_last});
        dmg_byte(8'($urandom), 6, 5, 1'b0, 8'h00, got);
        chk("busy_mid_stall", {31'd0, bus.busy}, 32'd1);
        wait_drain(TO + 50);
        chk("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
        chk("tx_ready_after_timeout", {31'd0, bus.tx_ready}, 32'd1);
        delta = to_cyc - last_rise_cyc;
        chk("timeout_window", {31'd0, (delta >= TO && delta <= TO + 4)}, 32'd1);
        xfer(8'h96, 6);

        // Reset mid-byte after 3 falling edges
        load_tx(8'h99);
        m_full = 1'b0;
        dmg_byte(8'($urandom), 6, 3, 1'b0, 8'h00, got);
        nreset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick(2);
        nreset = 1'b1;
        m_last = 8'h00;
        tick(3);
        load_tx(8'h5A);
        xfer(8'hC3, 8);

`ifdef LINK_PEER_MASTER_EN
        // Master mode: peer generates SCK, bench answers as the DMG slave
        load_tx(8'h81);
        m_full = 1'b0;
        expq.push_back('{is_to: 1'b0, data: 8'h5A});
        d = 8'h5A;
        got = 8'h00;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("master_sck_oe_on", {31'd0, bus.sck_oe}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (bus.sck_out && n < 2 * HP) begin
                tick(1);
                n++;
            end
            bus.sout = d[7-i];
            n = 0;
            while (!bus.sck_out && n < 2 * HP) begin
                tick(1);
                n++;
            end
            chk("master_low_phase", n, HP);
            got = {got[6:0], bus.sin};
        end
        n = 0;
        while (bus.sck_oe && n < 8) begin
            tick(1);
            n++;
        end
        chk("master_sck_oe_off", {31'd0, bus.sck_oe}, 32'd0);
        chk("master_sin_byte", {24'd0, got}, 32'h81);
        m_last = 8'h5A;
        wait_drain(50);
`else
        // Without the master build, start has no effect
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(20);
        chk("start_ignored_busy", {31'd0, bus.busy}, 32'd0);
        chk("start_ignored_oe", {31'd0, bus.sck_oe}, 32'd0);
        chk("start_ignored_sck_out", {31'd0, bus.sck_out}, 32'd1);
`endif

        tick(10);
        chk("final_queue_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/link_peer.md
# link_peer

Synthesizable model of the far end of the DMG link-cable serial port. The peer receives the bytes the DMG shifts out on SOUT and returns its own bytes on SIN, one bit per serial clock edge, MSB first. It normally runs as an external-clock slave to the DMG's internal 8192 Hz clock and can optionally act as clock master. It sits in the simulation top level alongside the CPU, on the SCK/SIN/SOUT pins.

## Interface
- HALF_PERIOD, 256: clk cycles per SCK half-period in master mode (4.194304 MHz / 8192 Hz / 2).
- TIMEOUT, 4096: clk cycles with no SCK edge mid-byte before the partial byte is aborted.

Ports:
- clk  in  1  system clock; all logic on posedge.
- nreset  in  1  reset, asynchronous, active-low.
- sck_in  in  1  serial clock from the DMG pin; asynchronous to clk; idles high.
- sout  in  1  DMG serial data out.
- sin  out  1  serial data driven to the DMG SIN pin.
- sck_out  out  1  generated serial clock; master mode only.
- sck_oe  out  1  high while sck_out drives the SCK net.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  the one-byte holding buffer is empty.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  a byte is in progress.
- start  in  1  one-cycle pulse that begins a master-mode byte; ignored without the macro.
- timeout_err  out  1  one-cycle pulse when a partial byte is aborted.

## Operation
- Clock input path:
  - sck_in goes through a 2-flop synchronizer, then a registered previous value for edge detection.
  - In master mode, the internally generated sck_out is used as the edge source instead.
- Holding buffer:
  - tx_valid && tx_ready loads tx_buf and clears tx_ready.
  - The buffer is freed (tx_ready=1) when a byte start consumes it.
- States and transitions:
  - IDLE -> SHIFT on a falling edge.
    - tx_sr loads tx_buf if full, else 0xFF (disconnected-cable value).
    - sin <= bit 7 of the loaded byte.
    - bit_cnt <= 0; busy <= 1.
  - SHIFT, rising edge: rx_sr <= {rx_sr[6:0], sout}; bit_cnt++.
    - On the 8th rising edge, rx_data <= the completed byte, rx_valid pulses, and the state returns to IDLE.
    - sin holds the last bit (bit 0).
  - SHIFT, falling edge: sin <= next bit of tx_sr.
  - SHIFT, no edge for TIMEOUT cycles: return to IDLE, timeout_err pulses, rx_data is unchanged, and the consumed tx byte is lost.
- Simultaneous events:
  - If tx_valid is accepted in the same cycle as a byte start, the start sees the buffer state from before that cycle. The new byte is held for the following transfer.
- Reset (any time, including mid-byte), all outputs and state take these values:
  - sin=1, sck_out=1, sck_oe=0.
  - tx_ready=1, rx_data=0x00, rx_valid=0, busy=0, timeout_err=0.
  - state=IDLE, tx_buf empty, bit_cnt=0.

## Timing
- sin changes 3 clk cycles after a sck_in falling edge (2 synchronizer stages plus 1 edge-detect stage).
- rx_valid asserts 3 clk cycles after the 8th sck_in rising edge.
- Minimum supported sck_in half-period is 4 clk cycles. Behaviour for shorter half-periods is undefined.
- tx_ready deasserts on the clk edge after acceptance and reasserts on the clk edge after the consuming byte start.
- The timeout counter resets on every detected edge. It counts only in SHIFT.

## Configuration
- LINK_PEER_MASTER_EN defined:
  - start in IDLE sets sck_oe=1.
  - The peer then drives sck_out low/high for 8 cycles of 2*HALF_PERIOD clk cycles, beginning with a low phase.
  - sck_oe drops one clk after the final rising edge.
  - start while busy is ignored.
  - The edge source is the internal sck_out (no synchronizer latency). sin updates 1 clk after each falling edge of sck_out.
- Not defined:
  - start is ignored; sck_out=1 and sck_oe=0 constantly.
  - The master counter and its states are not built.

## Test plan
- Reset mid-byte:
  - Stimulus: nreset low after 3 sck_in falling edges.
  - Response: all outputs return to their reset values immediately. The next full byte transfers correctly.
- Slave exchange:
  - Stimulus: tx_data=0xA5 accepted; DMG clocks out 0x3C at 8192 Hz.
  - Response: sin carries 1,0,1,0,0,1,0,1; rx_valid pulses once with rx_data=0x3C; tx_ready=1 after the first falling edge.
- Empty buffer:
  - Stimulus: no tx byte; DMG sends 0x00.
  - Response: sin stays 1 for all 8 bits; rx_data=0x00.
- Simultaneous load:
  - Stimulus: tx_valid with 0x11 in the same cycle as the first detected falling edge, with the buffer empty.
  - Response: the peer sends 0xFF; the next byte sends 0x11.
- Timeout:
  - Stimulus: stop sck_in after 5 rising edges.
  - Response: TIMEOUT cycles later timeout_err pulses, busy=0, and rx_data is unchanged.
- Master mode (macro on):
  - Stimulus: start pulse with tx_buf=0x81.
  - Response: sck_oe high; 8 low/high periods of HALF_PERIOD cycles each; sin carries 1,0,0,0,0,0,0,1; rx_valid pulses; sck_oe drops.
